// File: rtl/regalu_pipe.sv
// Register-file ALU with a two-stage ISSUE/EX pipeline, EX-to-ISSUE result
// forwarding, an external load port that shares the regfile write port, and a debug read port.
module regalu_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [AW-1:0]    src1,
  input  logic [AW-1:0]    src2,
  input  logic [AW-1:0]    dst,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_dst,
  output logic             out_zero,
  output logic             out_carry,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  // Returns {carry, result}. The carry is the ADD carry-out, the SUB borrow,
  // or the bit shifted out by SHL/SHR.
  function automatic logic [WIDTH:0] alu_calc(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = {(WIDTH+1){1'b0}};
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {(a < b), a - b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      3'd6:    r = {a[0], 1'b0, a[WIDTH-1:1]};
      3'd7:    r = {1'b0, a};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic             ex_valid_r;
  logic [2:0]       ex_op_r;
  logic [WIDTH-1:0] ex_a_r;
  logic [WIDTH-1:0] ex_b_r;
  logic [AW-1:0]    ex_dst_r;

  logic [WIDTH:0]   ex_res_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             ld_fire_s;
  logic             issue_s;

  // The EX writeback owns the write port, so a load can only land in an idle EX cycle.
  assign ld_ready  = !ex_valid_r;
  assign in_ready  = !(ld_en && ld_ready);
  assign ld_fire_s = ld_en && ld_ready;
  assign issue_s   = in_valid && in_ready;
  assign ex_res_s  = alu_calc(ex_op_r, ex_a_r, ex_b_r);
  assign dbg_data  = regs_r[dbg_addr];

  // Operand select: the result being written at this edge bypasses the array.
  always_comb begin
    op_a_s = regs_r[src1];
    op_b_s = regs_r[src2];
    if (ex_valid_r && (ex_dst_r == src1)) begin
      op_a_s = ex_res_s[WIDTH-1:0];
    end else begin
      op_a_s = regs_r[src1];
    end
    if (ex_valid_r && (ex_dst_r == src2)) begin
      op_b_s = ex_res_s[WIDTH-1:0];
    end else begin
      op_b_s = regs_r[src2];
    end
  end

  // Register file: EX writeback, or an accepted load when EX is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (ex_valid_r) begin
      regs_r[ex_dst_r] <= ex_res_s[WIDTH-1:0];
    end else if (ld_fire_s) begin
      regs_r[ld_addr] <= ld_data;
    end
  end

  // ISSUE -> EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= 3'd0;
      ex_a_r     <= {WIDTH{1'b0}};
      ex_b_r     <= {WIDTH{1'b0}};
      ex_dst_r   <= {AW{1'b0}};
    end else begin
      ex_valid_r <= issue_s;
      if (issue_s) begin
        ex_op_r  <= alu_op;
        ex_a_r   <= op_a_s;
        ex_b_r   <= op_b_s;
        ex_dst_r <= dst;
      end
    end
  end

  // Result outputs: one-cycle strobe, data and flags hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_dst   <= {AW{1'b0}};
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
    end else begin
      out_valid <= ex_valid_r;
      if (ex_valid_r) begin
        out_data  <= ex_res_s[WIDTH-1:0];
        out_dst   <= ex_dst_r;
        out_zero  <= (ex_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
        out_carry <= ex_res_s[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_regalu_pipe.sv
// Directed self-checking bench for regalu_pipe (WIDTH=8, DEPTH=8).
module tb_regalu_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_en, ld_ready, in_valid, in_ready;
  logic [AW-1:0]    ld_addr, src1, src2, dst, out_dst, dbg_addr;
  logic [WIDTH-1:0] ld_data, out_data, dbg_data;
  logic [2:0]       alu_op;
  logic             out_valid, out_zero, out_carry;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  regalu_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .src1(src1), .src2(src2), .dst(dst),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst),
    .out_zero(out_zero), .out_carry(out_carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d);
    in_valid = 1'b1; alu_op = op; src1 = s1; src2 = s2; dst = d;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    #1;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready_timeout: ld_ready=%b required 1", ld_ready); end
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    ld_en = 1'b0; in_valid = 1'b0; alu_op = 3'd0; src1 = '0; src2 = '0; dst = '0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;
    #2;
    checks++;
    if ({in_ready, ld_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b required 11", {in_ready, ld_ready}); end
    checks++;
    if ({out_valid, out_zero, out_carry, out_dst, out_data} !== 14'd0)
      begin errors++; $display("FAIL reset_outputs: got %h required 0", {out_valid, out_zero, out_carry, out_dst, out_data}); end
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h required 00", i, dbg_data); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_add;
    load(3'd1, 8'h02);
    load(3'd2, 8'h03);
    dbg_addr = 3'd3;
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b required 0", out_valid); end
    tick();
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd3, 8'h05})
      begin errors++; $display("FAIL add_result: got v=%b dst=%0d data=%h required v=1 dst=3 data=05", out_valid, out_dst, out_data); end
    checks++;
    if ({out_zero, out_carry} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b required 00", {out_zero, out_carry}); end
    checks++;
    if (dbg_data !== 8'h05) begin errors++; $display("FAIL add_dbg_r3: got %h required 05", dbg_data); end
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b0, 8'h05}) begin errors++; $display("FAIL add_hold: got v=%b data=%h required v=0 data=05", out_valid, out_data); end
  endtask

  task automatic test_back_to_back;
    issue(3'd2, 3'd1, 3'd2, 3'd5);
    tick();
    issue(3'd3, 3'd1, 3'd2, 3'd6);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd5, 8'h02})
      begin errors++; $display("FAIL b2b_and: got v=%b dst=%0d data=%h required v=1 dst=5 data=02", out_valid, out_dst, out_data); end
    tick();
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd6, 8'h03})
      begin errors++; $display("FAIL b2b_or: got v=%b dst=%0d data=%h required v=1 dst=6 data=03", out_valid, out_dst, out_data); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b required 0", out_valid); end
  endtask

  task automatic test_forward;
    load(3'd3, 8'h00);
    dbg_addr = 3'd4;
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    tick();
    issue(3'd0, 3'd3, 3'd3, 3'd4);
    tick();
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd3, 8'h05})
      begin errors++; $display("FAIL fwd_first: got v=%b dst=%0d data=%h required v=1 dst=3 data=05", out_valid, out_dst, out_data); end
    issue(3'd0, 3'd1, 3'd4, 3'd6);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd4, 8'h0A})
      begin errors++; $display("FAIL fwd_both: got v=%b dst=%0d data=%h required v=1 dst=4 data=0a", out_valid, out_dst, out_data); end
    checks++;
    if (dbg_data !== 8'h0A) begin errors++; $display("FAIL fwd_dbg_r4: got %h required 0a", dbg_data); end
    tick();
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd6, 8'h0C})
      begin errors++; $display("FAIL fwd_src2: got v=%b dst=%0d data=%h required v=1 dst=6 data=0c", out_valid, out_dst, out_data); end
  endtask

  task automatic test_sub_carry;
    load(3'd5, 8'h01);
    issue(3'd1, 3'd1, 3'd2, 3'd7);
    tick();
    issue(3'd0, 3'd7, 3'd5, 3'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_zero, out_carry, out_dst, out_data} !== {1'b1, 1'b0, 1'b1, 3'd7, 8'hFF})
      begin errors++; $display("FAIL sub_borrow: got v=%b z=%b c=%b dst=%0d data=%h required 1 0 1 7 ff", out_valid, out_zero, out_carry, out_dst, out_data); end
    tick();
    checks++;
    if ({out_valid, out_zero, out_carry, out_dst, out_data} !== {1'b1, 1'b1, 1'b1, 3'd0, 8'h00})
      begin errors++; $display("FAIL add_wrap: got v=%b z=%b c=%b dst=%0d data=%h required 1 1 1 0 00", out_valid, out_zero, out_carry, out_dst, out_data); end
  endtask

  // Registers here: r0=00 r1=02 r2=03 r3=05 r4=0a r5=01 r6=0c r7=ff
  task automatic test_ops;
    logic [2:0]  v_op [9];
    logic [2:0]  v_s1 [9];
    logic [2:0]  v_s2 [9];
    logic [9:0]  v_exp [9];
    v_op  = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd1, 3'd2, 3'd5, 3'd1};
    v_s1  = '{3'd1, 3'd7, 3'd2, 3'd1, 3'd7, 3'd2, 3'd3, 3'd1, 3'd3};
    v_s2  = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 3'd0, 3'd3};
    // {carry, zero, data}
    v_exp = '{{2'b00, 8'h01}, {2'b10, 8'hFE}, {2'b10, 8'h01}, {2'b00, 8'h01}, {2'b00, 8'hFF},
              {2'b00, 8'h01}, {2'b01, 8'h00}, {2'b00, 8'h04}, {2'b01, 8'h00}};
    for (int i = 0; i < 9; i++) begin
      issue(v_op[i], v_s1[i], v_s2[i], 3'd6);
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if ({out_valid, out_carry, out_zero, out_data} !== {1'b1, v_exp[i]})
        begin errors++; $display("FAIL op_vec%0d: got v=%b c=%b z=%b data=%h required v=1 cz/data=%h", i, out_valid, out_carry, out_zero, out_data, v_exp[i]); end
    end
  endtask

  task automatic test_load_stall;
    issue(3'd0, 3'd1, 3'd2, 3'd6);
    tick();
    in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd4; ld_data = 8'h5A;
    #1;
    checks++;
    if ({ld_ready, in_ready} !== 2'b01) begin errors++; $display("FAIL stall_busy: ld_ready/in_ready=%b required 01", {ld_ready, in_ready}); end
    tick();
    checks++;
    if ({out_valid, ld_ready, in_ready} !== 3'b110) begin errors++; $display("FAIL stall_drain: v/ld_ready/in_ready=%b required 110", {out_valid, ld_ready, in_ready}); end
    issue(3'd7, 3'd4, 3'd0, 3'd6);
    dbg_addr = 3'd4;
    tick();
    ld_en = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL stall_load_edge: v/in_ready=%b required 01", {out_valid, in_ready}); end
    checks++;
    if (dbg_data !== 8'h5A) begin errors++; $display("FAIL stall_dbg_r4: got %h required 5a", dbg_data); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_blocked_issue: got %b required 0", out_valid); end
    tick();
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd6, 8'h5A})
      begin errors++; $display("FAIL stall_pass: got v=%b dst=%0d data=%h required v=1 dst=6 data=5a", out_valid, out_dst, out_data); end
  endtask

  task automatic test_dst_src;
    issue(3'd0, 3'd2, 3'd2, 3'd2);
    tick();
    issue(3'd0, 3'd2, 3'd0, 3'd6);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd2, 8'h06})
      begin errors++; $display("FAIL dstsrc_self: got v=%b dst=%0d data=%h required v=1 dst=2 data=06", out_valid, out_dst, out_data); end
    tick();
    checks++;
    if ({out_valid, out_dst, out_data} !== {1'b1, 3'd6, 8'h06})
      begin errors++; $display("FAIL dstsrc_next: got v=%b dst=%0d data=%h required v=1 dst=6 data=06", out_valid, out_dst, out_data); end
  endtask

  task automatic test_reset_mid;
    issue(3'd0, 3'd1, 3'd2, 3'd6);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, ld_ready} !== 3'b011) begin errors++; $display("FAIL rst_mid_async: v/in/ld=%b required 011", {out_valid, in_ready, ld_ready}); end
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL rst_mid_reg%0d: got %h required 00", i, dbg_data); end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_data} !== 9'd0) begin errors++; $display("FAIL rst_mid_after: v=%b data=%h required 0 00", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_back_to_back();
    test_forward();
    test_sub_carry();
    test_ops();
    test_load_stall();
    test_dst_src();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regalu_pipe.md
REGALU_PIPE -- requirements
Module: regalu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of registers, operands and results.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (power of two, >=2); AW = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ld_en  input  1  external load request.
REQ-006 SHALL have port ld_addr  input  AW  load destination register.
REQ-007 SHALL have port ld_data  input  WIDTH  load value.
REQ-008 SHALL have port ld_ready  output  1  load accepted this cycle when ld_en && ld_ready.
REQ-009 SHALL have port in_valid  input  1  instruction request.
REQ-010 SHALL have port in_ready  output  1  instruction accepted when in_valid && in_ready.
REQ-011 SHALL have port alu_op  input  3  operation code.
REQ-012 SHALL have ports src1, src2, dst  input  AW each  operand and destination register indices.
REQ-013 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-014 SHALL have ports out_data  output  WIDTH, out_dst  output  AW  written value and register.
REQ-015 SHALL have ports out_zero, out_carry  output  1 each  result flags.
REQ-016 SHALL have ports dbg_addr  input  AW, dbg_data  output  WIDTH  combinational register read.

Function
REQ-017 SHALL implement opcodes: 0 ADD, 1 SUB (src1-src2), 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR by 1 (logical), 7 PASS src1.
REQ-018 SHALL truncate results to WIDTH; out_carry = bit WIDTH of ADD, borrow (src1<src2) for SUB, bit shifted out for SHL/SHR, 0 otherwise.
REQ-019 SHALL set out_zero = 1 iff the truncated result is 0.
REQ-020 SHALL use a two-stage pipeline: ISSUE (operand read, accept edge k) and EX (compute, regfile write and output update at edge k+1).
REQ-021 SHALL assert out_valid for exactly the one cycle following edge k+1, with out_data/out_dst/flags valid that cycle; outputs hold last value otherwise.
REQ-022 SHALL sustain one instruction per cycle when no load fires.
REQ-023 SHALL forward the EX-stage result to an ISSUE-stage operand whose index equals the in-flight dst (either or both operands).
REQ-024 SHALL drive ld_ready = !ex_valid (the EX-stage writeback owns the write port).
REQ-025 SHALL drive in_ready = !(ld_en && ld_ready); a firing load blocks issue that cycle.
REQ-026 SHALL write ld_data to ld_addr at the accepting edge; no out_valid pulse for loads.
REQ-027 SHALL make a load visible to instructions issued on any later cycle.
REQ-028 SHALL drive dbg_data from the register array only (no forwarding).
REQ-029 SHALL allow dst equal to src1/src2; operands use the pre-write value.

Reset
REQ-030 SHALL on rst_n low, immediately and independent of clk, clear all registers to 0, ex_valid, out_valid, out_data, out_dst, out_zero, out_carry to 0.
REQ-031 SHALL discard any in-flight EX instruction on reset, with no register write.
REQ-032 SHALL have in_ready = 1 and ld_ready = 1 while in reset with ld_en low.

Verification
REQ-033 SHALL cover: load r1=2, r2=3, then ADD r3=r1+r2 -> out_valid one cycle after the accept edge, out_data=5, out_dst=3, dbg r3=5.
REQ-034 SHALL cover: AND then OR on r1=010, r2=011 -> 010 then 011, back-to-back, two consecutive out_valid cycles.
REQ-035 SHALL cover: ADD r3=r1+r2 then next cycle ADD r4=r3+r3 -> r4=10 via forwarding, no stall.
REQ-036 SHALL cover: SUB r1-r2 with 2,3 -> out_data=0xFF, out_carry=1; ADD 0xFF+0x01 -> 0, zero=1, carry=1.
REQ-037 SHALL cover: ld_en held while EX busy -> ld_ready=0 until EX drains; load fires with in_ready=0 that cycle.
REQ-038 SHALL cover: rst_n pulsed low mid-instruction -> no out_valid, all registers read 0 via dbg port.
